// File: rtl/serial_pkg.sv
// Shared types for the serial link (p2s / s2p_rx).
// Receiver state and default word width.
package serial_pkg;

  localparam int DEFAULT_WORD_W = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } rx_state_t;

endpackage

// File: rtl/s2p_rx_if.sv
// Serial-in and parallel-out handshake bundle for s2p_rx.
// master drives the link, slave is the receiver.
interface s2p_rx_if
  import serial_pkg::*;
#(
  parameter int N = DEFAULT_WORD_W
);

  logic         ser_valid;
  logic         ser_data;
  logic         ser_ready;
  logic         flush;
  logic         par_ready;
  logic         par_valid;
  logic [N-1:0] par_data;

  modport master (
    output ser_valid,
    output ser_data,
    output flush,
    output par_ready,
    input  ser_ready,
    input  par_valid,
    input  par_data
  );

  modport slave (
    input  ser_valid,
    input  ser_data,
    input  flush,
    input  par_ready,
    output ser_ready,
    output par_valid,
    output par_data
  );

endinterface

// File: rtl/s2p_rx.sv
// Double-buffered LSB-first serial-to-parallel receiver.
// Shift register fills while the output register holds a word.
module s2p_rx
  import serial_pkg::*;
#(
  parameter int N = DEFAULT_WORD_W
) (
  input  logic      clk,
  input  logic      rstn,
  s2p_rx_if.slave   bus
);

  localparam int CNT_W = $clog2(N);

  rx_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0] sreg_q, sreg_d;
  logic [N-1:0] pdata_q;
  logic         pvalid_q;

  logic         ready;
  logic         load;
  logic [N-1:0] word;
  logic [N-1:0] shifted;
  logic         last;
  logic         drain;

  assign shifted = {bus.ser_data, sreg_q[N-1:1]};
  assign last    = (cnt_q == CNT_W'(N-1));
  assign drain   = pvalid_q && bus.par_ready;

  assign bus.ser_ready = ready;
  assign bus.par_valid = pvalid_q;
  assign bus.par_data  = pdata_q;

  // Next state, bit counter, shift register and output-load decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    ready   = 1'b0;
    load    = 1'b0;
    word    = sreg_q;
    unique case (state_q)
      COLLECT: begin
        ready = !bus.flush;
        if (bus.flush) begin
          cnt_d  = '0;
          sreg_d = '0;
        end else if (bus.ser_valid) begin
          sreg_d = shifted;
          if (last) begin
            cnt_d = '0;
            if (!pvalid_q || drain) begin
              load = 1'b1;
              word = shifted;
            end else begin
              state_d = STALL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STALL: begin
        if (bus.flush) begin
          cnt_d   = '0;
          sreg_d  = '0;
          state_d = COLLECT;
        end else if (bus.par_ready) begin
          load    = 1'b1;
          word    = sreg_q;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State, bit counter and shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  // Output register: load a new word, else clear valid on drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
    end else if (load) begin
      pdata_q  <= word;
      pvalid_q <= 1'b1;
    end else if (drain) begin
      pvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s2p_rx.sv
// Bench for s2p_rx: word-queue reference model,
// directed literal cases and randomized loopback.
module tb_s2p_rx;
  import serial_pkg::*;

  localparam int N = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  s2p_rx_if #(.N(N)) bus ();

  s2p_rx #(.N(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0] pend[$];
  logic [N-1:0] acc;
  logic [N-1:0] lastw;
  int           nb;
  logic [N-1:0] rxq[$];
  logic [N-1:0] srcq[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endfunction

  // One cycle: drive, compare against model, advance model.
  task automatic cyc(input logic v, input logic d,
                     input logic f, input logic pr);
    bit exp_rdy;
    bit drn;
    bit acc_ok;
    int held;
    @(negedge clk);
    bus.ser_valid = v;
    bus.ser_data  = d;
    bus.flush     = f;
    bus.par_ready = pr;
    #1;
    exp_rdy = !f && (pend.size() < 2);
    chk("ser_ready", 32'(bus.ser_ready), 32'(exp_rdy));
    chk("par_valid", 32'(bus.par_valid), 32'(pend.size() > 0));
    if (pend.size() > 0)
      chk("par_data", 32'(bus.par_data), 32'(pend[0]));
    else
      chk("par_data_keep", 32'(bus.par_data), 32'(lastw));
    if (bus.par_valid && pr) rxq.push_back(bus.par_data);
    drn    = (pend.size() > 0) && pr;
    acc_ok = v && exp_rdy;
    held   = pend.size();
    if (drn) lastw = pend.pop_front();
    if (f) begin
      nb  = 0;
      acc = '0;
      if (held == 2) void'(pend.pop_back());
    end
    if (acc_ok) begin
      acc[nb] = d;
      nb++;
      if (nb == N) begin
        pend.push_back(acc);
        nb = 0;
      end
    end
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic pr);
    for (int i = 0; i < N; i++) cyc(1'b1, w[i], 1'b0, pr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn          = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_data  = 1'b0;
    bus.flush     = 1'b0;
    bus.par_ready = 1'b0;
    pend.delete();
    nb    = 0;
    acc   = '0;
    lastw = '0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]   w8;
    logic [N-1:0] cur;
    int           bi;
    int           cyc_n;
    bit           will_acc;
    logic         v;
    logic         pr;

    bus.ser_valid = 1'b0;
    bus.ser_data  = 1'b0;
    bus.flush     = 1'b0;
    bus.par_ready = 1'b0;
    nb    = 0;
    acc   = '0;
    lastw = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // reset mid-word, then a clean word
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus.par_valid), 32'h0);
    chk("t1_data", 32'(bus.par_data), 32'h0);
    chk("t1_ready", 32'(bus.ser_ready), 32'h1);
    send_word(4'b1101, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_word", 32'(bus.par_data), 32'hD);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // single-cycle valid pulse
    send_word(4'b1101, 1'b1);
    chk("t2_pre", 32'(bus.par_valid), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_pulse", 32'(bus.par_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_drop", 32'(bus.par_valid), 32'h0);

    // back-to-back words, no bubbles
    w8 = 8'h5A;
    for (int j = 0; j <= 8; j++) begin
      if (j < 8) cyc(1'b1, w8[j], 1'b0, 1'b1);
      else       cyc(1'b0, 1'b0, 1'b0, 1'b1);
      if (j < 8) chk("t3_ready", 32'(bus.ser_ready), 32'h1);
      chk("t3_valid", 32'(bus.par_valid), 32'((j == 4) || (j == 8)));
      if (j == 4) chk("t3_dataA", 32'(bus.par_data), 32'hA);
      if (j == 8) chk("t3_data5", 32'(bus.par_data), 32'h5);
    end

    // stall with full output register
    send_word(4'h3, 1'b0);
    send_word(4'hC, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_stall_rdy", 32'(bus.ser_ready), 32'h0);
    chk("t4_hold3", 32'(bus.par_data), 32'h3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_dataC", 32'(bus.par_data), 32'hC);
    chk("t4_validC", 32'(bus.par_valid), 32'h1);
    chk("t4_rdy_back", 32'(bus.ser_ready), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // flush partial word, held word kept
    send_word(4'h6, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_flush_rdy", 32'(bus.ser_ready), 32'h0);
    send_word(4'h9, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_hold6", 32'(bus.par_data), 32'h6);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_data9", 32'(bus.par_data), 32'h9);
    chk("t5_valid9", 32'(bus.par_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_empty", 32'(bus.par_valid), 32'h0);

    // randomized loopback from a word source
    rxq.delete();
    srcq.delete();
    cur   = N'($urandom);
    bi    = 0;
    cyc_n = 0;
    while (rxq.size() < 1000 && cyc_n < 60000) begin
      v        = ($urandom_range(0, 3) != 0);
      pr       = 1'($urandom_range(0, 1));
      will_acc = v && (pend.size() < 2);
      cyc(v, cur[bi], 1'b0, pr);
      if (will_acc) begin
        bi++;
        if (bi == N) begin
          srcq.push_back(cur);
          cur = N'($urandom);
          bi  = 0;
        end
      end
      cyc_n++;
    end
    chk("t6_count", 32'(rxq.size() >= 1000), 32'h1);
    for (int i = 0; i < rxq.size(); i++) begin
      if (i < srcq.size())
        chk("t6_word", 32'(rxq[i]), 32'(srcq[i]));
      else
        chk("t6_extra", 32'h1, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
